// File: rtl/trap_csr_pkg.sv
// trap_csr_pkg: CSR addresses, trap cause codes and Zicsr op encodings shared by the trap controller
package trap_csr_pkg;
  localparam int MXLEN = 32;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [MXLEN-1:0] CAUSE_I_MIS     = 32'd0;
  localparam logic [MXLEN-1:0] CAUSE_ILLEGAL   = 32'd2;
  localparam logic [MXLEN-1:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [MXLEN-1:0] CAUSE_L_MIS     = 32'd4;
  localparam logic [MXLEN-1:0] CAUSE_S_MIS     = 32'd6;
  localparam logic [MXLEN-1:0] CAUSE_ECALL     = 32'd11;
  localparam logic [MXLEN-1:0] CAUSE_IRQ_TIMER = 32'h8000_0007;
  localparam logic [MXLEN-1:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
  function automatic logic [MXLEN-1:0] csr_apply(input csr_op_e op, input logic [MXLEN-1:0] old, input logic [MXLEN-1:0] w);
    return op == OP_RW ? w : op == OP_RS ? (old | w) : op == OP_RC ? (old & ~w) : old;
  endfunction
endpackage

// File: rtl/trap_csr_counter64.sv
// csr_counter64: 64-bit counter with increment enable and independently writable 32-bit halves
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);
  // a write to either half replaces the increment for the whole 64-bit value
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (wr_lo) value <= {value[63:32], wdata};
    else if (wr_hi) value <= {wdata, value[31:0]};
    else if (inc) value <= value + 64'd1;
endmodule

// File: rtl/trap_csr.sv
// trap_csr: machine-mode trap prioritisation, mret handling, Zicsr CSR file and cycle/instret counters
module trap_csr
  import trap_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [MXLEN-1:0] pc_val,
  input  logic             instr_retire,
  input  logic             csr_en,
  input  logic [2:0]       csr_ops,
  input  logic [11:0]      csr_addr,
  input  logic [MXLEN-1:0] csr_w_data,
  output logic [MXLEN-1:0] csr_r_data,
  input  logic             exc_illegal,
  input  logic             exc_ecall,
  input  logic             exc_ebreak,
  input  logic             exc_l_misaligned,
  input  logic             exc_s_misaligned,
  input  logic             i_misaligned,
  input  logic [MXLEN-1:0] bad_addr,
  input  logic             mret_req,
  input  logic             irq_timer,
  input  logic             irq_ext,
  output logic             exception,
  output logic             mret,
  output logic [MXLEN-1:0] mtvec_or_mepc
);
  logic st_mie, st_mpie, ie_ext, ie_tmr, known, wr_type, csr_ill, csr_we, sync_exc, irq_take, unused_imm;
  logic [MXLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, cause, base, target, new_val, rd;
  logic [63:0] mcycle, minstret;
  csr_op_e op;
  assign unused_imm = csr_ops[2];
  assign op = csr_op_e'(csr_ops[1:0]);
  // RS/RC with a zero operand is a pure read, so csrr of a read-only CSR stays legal
  assign wr_type = csr_en & (op == OP_RW | (op != OP_NONE & |csr_w_data));
  assign csr_ill = csr_en & (~known | (wr_type & csr_addr[11:8] == 4'hF));
  assign csr_we = wr_type & ~exception;
  assign new_val = csr_apply(op, csr_r_data, csr_w_data);
  assign csr_r_data = rd;
  // read mux; unknown addresses read 0 and flag an illegal access
  always_comb begin
    rd = '0;
    known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   rd = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      CSR_MISA:      rd = MISA_VAL;
      CSR_MIE:       rd = {20'b0, ie_ext, 3'b0, ie_tmr, 7'b0};
      CSR_MTVEC:     rd = mtvec;
      CSR_MSCRATCH:  rd = mscratch;
      CSR_MEPC:      rd = mepc;
      CSR_MCAUSE:    rd = mcause;
      CSR_MTVAL:     rd = mtval;
      CSR_MIP:       rd = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
      CSR_MCYCLE:    rd = mcycle[31:0];
      CSR_MCYCLEH:   rd = mcycle[63:32];
      CSR_MINSTRET:  rd = minstret[31:0];
      CSR_MINSTRETH: rd = minstret[63:32];
      CSR_MHARTID:   rd = HART_ID;
      default:       known = 1'b0;
    endcase
  end
  assign sync_exc = exc_illegal | csr_ill | exc_ecall | exc_ebreak | i_misaligned | exc_s_misaligned | exc_l_misaligned;
  assign irq_take = st_mie & ~sync_exc & ((irq_ext & ie_ext) | (irq_timer & ie_tmr));
  assign exception = ~RST & (sync_exc | irq_take);
  assign mret = ~RST & mret_req & ~exception;
  assign cause = (exc_illegal | csr_ill) ? CAUSE_ILLEGAL : exc_ecall ? CAUSE_ECALL : exc_ebreak ? CAUSE_EBREAK :
                 i_misaligned ? CAUSE_I_MIS : exc_s_misaligned ? CAUSE_S_MIS : exc_l_misaligned ? CAUSE_L_MIS :
                 (irq_ext & ie_ext) ? CAUSE_IRQ_EXT : CAUSE_IRQ_TIMER;
  assign base = {mtvec[31:2], 2'b00};
  assign target = (mtvec[0] & ~sync_exc) ? base + {26'b0, cause[3:0], 2'b00} : base;
  assign mtvec_or_mepc = exception ? target : mepc;
  // trap entry beats mret, which beats a CSR write; mepc points one word back since return adds 4
  always_ff @(posedge CLK)
    if (RST) begin
      st_mie <= 1'b0;
      st_mpie <= 1'b0;
      ie_ext <= 1'b0;
      ie_tmr <= 1'b0;
      mtvec <= MTVEC_RST;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
    end else if (exception) begin
      mepc <= (pc_val - 32'd4) & ~32'd3;
      mcause <= cause;
      mtval <= (cause == CAUSE_L_MIS || cause == CAUSE_S_MIS) ? bad_addr : '0;
      st_mpie <= st_mie;
      st_mie <= 1'b0;
    end else if (mret) begin
      st_mie <= st_mpie;
      st_mpie <= 1'b1;
    end else if (csr_we)
      case (csr_addr)
        CSR_MSTATUS: begin
          st_mie <= new_val[3];
          st_mpie <= new_val[7];
        end
        CSR_MIE: begin
          ie_ext <= new_val[11];
          ie_tmr <= new_val[7];
        end
        CSR_MTVEC:    mtvec <= new_val & ~32'd2;
        CSR_MSCRATCH: mscratch <= new_val;
        CSR_MEPC:     mepc <= new_val & ~32'd3;
        CSR_MCAUSE:   mcause <= new_val;
        CSR_MTVAL:    mtval <= new_val;
        default: ;
      endcase
  csr_counter64 u_mcycle (
    .clk(CLK), .rst(RST), .inc(1'b1),
    .wr_lo(csr_we & csr_addr == CSR_MCYCLE), .wr_hi(csr_we & csr_addr == CSR_MCYCLEH),
    .wdata(new_val), .value(mcycle)
  );
  csr_counter64 u_minstret (
    .clk(CLK), .rst(RST), .inc(instr_retire & ~exception),
    .wr_lo(csr_we & csr_addr == CSR_MINSTRET), .wr_hi(csr_we & csr_addr == CSR_MINSTRETH),
    .wdata(new_val), .value(minstret)
  );
endmodule

// File: tb/tb_trap_csr.sv
// tb_trap_csr: scoreboard bench for trap_csr; expectations queued at stimulus, compared on observation
module tb_trap_csr;
  logic CLK = 1'b0, RST, instr_retire, csr_en, exc_illegal, exc_ecall, exc_ebreak, exc_l_misaligned;
  logic exc_s_misaligned, i_misaligned, mret_req, irq_timer, irq_ext, exception, mret;
  logic [2:0] csr_ops;
  logic [11:0] csr_addr;
  logic [31:0] pc_val, csr_w_data, csr_r_data, bad_addr, mtvec_or_mepc;
  typedef struct {string name; logic [31:0] val;} exp_t;
  exp_t sb[$];
  logic [31:0] got[$];
  int checks = 0, failures = 0;
  logic [5:0] pat [5] = '{6'b000001, 6'b000011, 6'b000110, 6'b001100, 6'b011000};
  logic [31:0] pcause [5] = '{32'd4, 32'd6, 32'd0, 32'd3, 32'd11};

  trap_csr dut (
    .CLK(CLK), .RST(RST), .pc_val(pc_val), .instr_retire(instr_retire), .csr_en(csr_en),
    .csr_ops(csr_ops), .csr_addr(csr_addr), .csr_w_data(csr_w_data), .csr_r_data(csr_r_data),
    .exc_illegal(exc_illegal), .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak),
    .exc_l_misaligned(exc_l_misaligned), .exc_s_misaligned(exc_s_misaligned),
    .i_misaligned(i_misaligned), .bad_addr(bad_addr), .mret_req(mret_req),
    .irq_timer(irq_timer), .irq_ext(irq_ext), .exception(exception), .mret(mret),
    .mtvec_or_mepc(mtvec_or_mepc)
  );

  always #5 CLK = ~CLK;

  task automatic want(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic obs(input logic [31:0] v);
    got.push_back(v);
  endtask

  task automatic peek(input logic [11:0] a);
    csr_addr = a;
    #1;
    got.push_back(csr_r_data);
  endtask

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    {instr_retire, csr_en, exc_illegal, exc_ecall, exc_ebreak, exc_l_misaligned} = '0;
    {exc_s_misaligned, i_misaligned, mret_req, irq_timer, irq_ext} = '0;
    csr_ops = '0;
    csr_addr = '0;
    pc_val = '0;
    csr_w_data = '0;
    bad_addr = '0;
  endtask

  task automatic do_csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] w,
                        output logic [31:0] old, output logic ex);
    csr_en = 1'b1;
    csr_ops = op;
    csr_addr = a;
    csr_w_data = w;
    #1;
    old = csr_r_data;
    ex = exception;
    sync();
    csr_en = 1'b0;
    csr_ops = '0;
    csr_w_data = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] o;
    repeat (2) @(posedge CLK);
    #1;
    exc_ecall = 1'b1;
    mret_req = 1'b1;
    irq_ext = 1'b1;
    #1;
    want("rst_exception", 0); obs({31'b0, exception});
    want("rst_mret", 0); obs({31'b0, mret});
    idle();
    want("rst_mtvec", 32'h100); peek(12'h305);
    want("rst_mstatus", 32'h1800); peek(12'h300);
    want("rst_mepc", 0); peek(12'h341);
    want("rst_misa", 32'h4000_0100); peek(12'h301);
    want("rst_mhartid", 0); peek(12'hF14);
    RST = 1'b0;
    sync();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_ecall();
    exp_t e;
    logic [31:0] o;
    pc_val = 32'h200;
    exc_ecall = 1'b1;
    #1;
    want("ecall_exception", 1); obs({31'b0, exception});
    want("ecall_target", 32'h100); obs(mtvec_or_mepc);
    want("ecall_mret", 0); obs({31'b0, mret});
    sync();
    idle();
    want("ecall_mepc", 32'h1FC); peek(12'h341);
    want("ecall_mcause", 32'd11); peek(12'h342);
    want("ecall_mstatus", 32'h1800); peek(12'h300);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_irq();
    exp_t e;
    logic [31:0] o, old;
    logic ex;
    do_csr(3'b001, 12'h305, 32'h103, old, ex);
    want("irq_mtvec_old", 32'h100); obs(old);
    want("irq_mtvec_mode", 32'h101); peek(12'h305);
    do_csr(3'b001, 12'h304, 32'h800, old, ex);
    irq_ext = 1'b1;
    irq_timer = 1'b1;
    pc_val = 32'h300;
    #1;
    want("irq_masked_by_mie", 0); obs({31'b0, exception});
    want("irq_mip_live", 32'h880); peek(12'h344);
    idle();
    sync();
    do_csr(3'b010, 12'h300, 32'h8, old, ex);
    want("irq_mstatus_old", 32'h1800); obs(old);
    irq_timer = 1'b1;
    pc_val = 32'h300;
    #1;
    want("irq_timer_disabled", 0); obs({31'b0, exception});
    irq_ext = 1'b1;
    #1;
    want("irq_ext_exception", 1); obs({31'b0, exception});
    want("irq_ext_target", 32'h12C); obs(mtvec_or_mepc);
    sync();
    idle();
    want("irq_mcause", 32'h8000_000B); peek(12'h342);
    want("irq_mepc", 32'h2FC); peek(12'h341);
    want("irq_mstatus", 32'h1880); peek(12'h300);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_mret();
    exp_t e;
    logic [31:0] o, old;
    logic ex;
    do_csr(3'b001, 12'h341, 32'h1FE, old, ex);
    want("mret_mepc_masked", 32'h1FC); peek(12'h341);
    mret_req = 1'b1;
    #1;
    want("mret_out", 1); obs({31'b0, mret});
    want("mret_target", 32'h1FC); obs(mtvec_or_mepc);
    want("mret_exception", 0); obs({31'b0, exception});
    sync();
    idle();
    want("mret_mstatus", 32'h1888); peek(12'h300);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    logic [31:0] o, old, bad;
    logic ex;
    exc_illegal = 1'b1;
    exc_l_misaligned = 1'b1;
    mret_req = 1'b1;
    bad_addr = 32'h1003;
    pc_val = 32'h400;
    #1;
    want("prio_exception", 1); obs({31'b0, exception});
    want("prio_mret_blocked", 0); obs({31'b0, mret});
    want("prio_sync_target", 32'h100); obs(mtvec_or_mepc);
    sync();
    idle();
    want("prio_mcause", 32'd2); peek(12'h342);
    want("prio_mtval", 0); peek(12'h343);
    want("prio_mepc", 32'h3FC); peek(12'h341);
    want("prio_mstatus", 32'h1880); peek(12'h300);
    for (int i = 0; i < 5; i++) begin
      bad = 32'h1000 + 32'(i) * 32'h11;
      {exc_illegal, exc_ecall, exc_ebreak, i_misaligned, exc_s_misaligned, exc_l_misaligned} = pat[i];
      bad_addr = bad;
      #1;
      want("tbl_exception", 1); obs({31'b0, exception});
      sync();
      idle();
      want("tbl_mcause", pcause[i]); peek(12'h342);
      want("tbl_mtval", (pcause[i] == 32'd4 || pcause[i] == 32'd6) ? bad : 32'd0); peek(12'h343);
    end
    do_csr(3'b010, 12'h300, 32'h8, old, ex);
    irq_ext = 1'b1;
    exc_s_misaligned = 1'b1;
    bad_addr = 32'h55;
    #1;
    want("sync_over_irq_target", 32'h100); obs(mtvec_or_mepc);
    sync();
    idle();
    want("sync_over_irq_mcause", 32'd6); peek(12'h342);
    want("sync_over_irq_mtval", 32'h55); peek(12'h343);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_csr_ops();
    exp_t e;
    logic [31:0] o, old;
    logic ex;
    do_csr(3'b001, 12'h304, 32'h0, old, ex);
    want("rw_mie_old", 32'h800); obs(old);
    do_csr(3'b010, 12'h304, 32'h880, old, ex);
    want("rs_mie_old", 0); obs(old);
    do_csr(3'b011, 12'h304, 32'h80, old, ex);
    want("rc_mie_old", 32'h880); obs(old);
    want("mie_final", 32'h800); peek(12'h304);
    do_csr(3'b001, 12'h301, 32'h0, old, ex);
    want("misa_old", 32'h4000_0100); obs(old);
    want("misa_write_legal", 0); obs({31'b0, ex});
    want("misa_kept", 32'h4000_0100); peek(12'h301);
    do_csr(3'b010, 12'hF14, 32'h0, old, ex);
    want("mhartid_read_legal", 0); obs({31'b0, ex});
    do_csr(3'b001, 12'hF14, 32'h5, old, ex);
    want("mhartid_write_traps", 1); obs({31'b0, ex});
    want("mhartid_write_cause", 32'd2); peek(12'h342);
    do_csr(3'b010, 12'h7C0, 32'h0, old, ex);
    want("unknown_csr_traps", 1); obs({31'b0, ex});
    exc_ecall = 1'b1;
    do_csr(3'b001, 12'h340, 32'hDEAD, old, ex);
    exc_ecall = 1'b0;
    want("write_dropped_on_trap", 0); peek(12'h340);
    do_csr(3'b001, 12'h340, 32'hBEEF, old, ex);
    want("mscratch_write", 32'hBEEF); peek(12'h340);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_counter();
    exp_t e;
    logic [31:0] o, old;
    logic ex;
    do_csr(3'b001, 12'hB80, 32'h0, old, ex);
    do_csr(3'b001, 12'hB00, 32'hFFFF_FFFF, old, ex);
    want("mcycle_pre_carry", 32'hFFFF_FFFF); peek(12'hB00);
    want("mcycleh_pre_carry", 0); peek(12'hB80);
    sync();
    want("mcycle_after_carry", 0); peek(12'hB00);
    want("mcycleh_after_carry", 1); peek(12'hB80);
    do_csr(3'b001, 12'hB00, 32'hFFFF_FFFF, old, ex);
    do_csr(3'b001, 12'hB00, 32'h5, old, ex);
    want("mcycle_old_pre_inc", 32'hFFFF_FFFF); obs(old);
    want("mcycle_override", 32'h5); peek(12'hB00);
    want("mcycleh_override", 1); peek(12'hB80);
    do_csr(3'b001, 12'hB82, 32'h0, old, ex);
    do_csr(3'b001, 12'hB02, 32'h7, old, ex);
    instr_retire = 1'b1;
    repeat (3) sync();
    exc_ebreak = 1'b1;
    sync();
    idle();
    want("minstret_count", 32'd10); peek(12'hB02);
    want("minstreth_count", 0); peek(12'hB82);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_reset_trap();
    exp_t e;
    logic [31:0] o;
    pc_val = 32'h600;
    exc_ecall = 1'b1;
    RST = 1'b1;
    #1;
    want("rst_trap_exception", 0); obs({31'b0, exception});
    sync();
    idle();
    RST = 1'b0;
    want("rst_trap_mepc", 0); peek(12'h341);
    want("rst_trap_mcause", 0); peek(12'h342);
    want("rst_trap_mtvec", 32'h100); peek(12'h305);
    sync();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  initial begin
    idle();
    RST = 1'b1;
    test_reset();
    test_ecall();
    test_irq();
    test_mret();
    test_priority();
    test_csr_ops();
    test_counter();
    test_reset_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
